// File: rtl/amstrad_ram_arbiter.sv
// Single-port RAM/ROM arbiter: grants video, CPU or DMA one access at a time,
// holds the memory strobes for LAT cycles, returns read data and a one-cycle ack.
module amstrad_ram_arbiter #(
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned LAT        = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_dout,
  output logic              vid_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_din,
  output logic [7:0]        dma_dout,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  output logic              mem_oe,
  output logic              mem_we,
  output logic              busy
);

  localparam logic [3:0] LAT_LOAD   = 4'(LAT - 1);
  localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU, OWN_DMA} owner_t;

  state_t     state;
  owner_t     owner;
  logic [3:0] lat_cnt;
  logic [3:0] starve_cnt;

  logic dma_starved;
  logic grant_vid;
  logic grant_cpu;
  logic grant_dma;

  // Priority decode: video first, starved DMA next, then CPU, then DMA.
  always_comb begin
    dma_starved = dma_req && (starve_cnt == STARVE_TOP);
    grant_vid   = vid_req;
    grant_dma   = !vid_req && dma_req && (dma_starved || !cpu_req);
    grant_cpu   = !vid_req && cpu_req && !dma_starved;
  end

  // Arbitration FSM with registered strobes, acks and per-requester read data.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      lat_cnt    <= 4'd0;
      starve_cnt <= 4'd0;
      vid_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      mem_oe     <= 1'b0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= 8'd0;
      vid_dout   <= 8'd0;
      cpu_dout   <= 8'd0;
      dma_dout   <= 8'd0;
    end else begin
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (!dma_req) starve_cnt <= 4'd0;
          if (grant_vid) begin
            owner    <= OWN_VID;
            mem_addr <= vid_addr;
            mem_oe   <= 1'b1;
            mem_we   <= 1'b0;
          end else if (grant_dma) begin
            owner      <= OWN_DMA;
            mem_addr   <= dma_addr;
            mem_din    <= dma_din;
            mem_we     <= dma_we;
            mem_oe     <= !dma_we;
            starve_cnt <= 4'd0;
          end else if (grant_cpu) begin
            owner    <= OWN_CPU;
            mem_addr <= cpu_addr;
            mem_din  <= cpu_din;
            mem_we   <= cpu_we;
            mem_oe   <= !cpu_we;
            if (dma_req && (starve_cnt < STARVE_TOP)) starve_cnt <= starve_cnt + 4'd1;
          end
          if (vid_req || cpu_req || dma_req) begin
            lat_cnt <= LAT_LOAD;
            busy    <= 1'b1;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (lat_cnt == 4'd0) begin
            case (owner)
              OWN_VID: begin
                vid_dout <= mem_dout;
                vid_ack  <= 1'b1;
              end
              OWN_CPU: begin
                if (mem_oe) cpu_dout <= mem_dout;
                cpu_ack <= 1'b1;
              end
              OWN_DMA: begin
                if (mem_oe) dma_dout <= mem_dout;
                dma_ack <= 1'b1;
              end
              default: ;
            endcase
            mem_oe <= 1'b0;
            mem_we <= 1'b0;
            state  <= DONE;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          owner <= OWN_NONE;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_amstrad_ram_arbiter.sv
// Directed bench for amstrad_ram_arbiter with an ack-ordered scoreboard.
module tb_amstrad_ram_arbiter;

  localparam int unsigned ADDR_W = 23;
  localparam logic [1:0] W_VID = 2'd1;
  localparam logic [1:0] W_CPU = 2'd2;
  localparam logic [1:0] W_DMA = 2'd3;

  logic              CLK;
  logic              reset;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [7:0]        vid_dout;
  logic              vid_ack;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_din;
  logic [7:0]        cpu_dout;
  logic              cpu_ack;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [7:0]        dma_din;
  logic [7:0]        dma_dout;
  logic              dma_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic [7:0]        mem_data;
  logic              mem_oe;
  logic              mem_we;
  logic              busy;

  amstrad_ram_arbiter dut (
    .CLK(CLK), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_ack(vid_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
    .dma_dout(dma_dout), .dma_ack(dma_ack),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_data),
    .mem_oe(mem_oe), .mem_we(mem_we), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] who;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Per-window observation counters.
  int cyc, n_oe, n_we, n_busy, n_vack, n_cack, n_dack, n_addr_bad, n_din_bad;
  int rises[$];
  logic busy_prev;
  logic chk_addr;
  logic starve_chk;
  int cpu_drop_after;
  logic [ADDR_W-1:0] exp_addr;
  logic [7:0] exp_din;
  logic [7:0] m_vid, m_cpu, m_dma;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] who, input logic [7:0] data);
    exp_t e;
    e.who  = who;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic clear_win();
    cyc = 0; n_oe = 0; n_we = 0; n_busy = 0;
    n_vack = 0; n_cack = 0; n_dack = 0; n_addr_bad = 0; n_din_bad = 0;
    rises.delete();
    busy_prev = busy;
  endtask

  // Advance n cycles, sampling on the falling edge and playing the requesters.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge CLK);
      cyc++;
      if (mem_oe) n_oe++;
      if (mem_we) n_we++;
      if (busy) n_busy++;
      if (busy && !busy_prev) rises.push_back(cyc);
      busy_prev = busy;
      if (chk_addr && (mem_oe || mem_we) && (mem_addr !== exp_addr)) n_addr_bad++;
      if (mem_we && (mem_din !== exp_din)) n_din_bad++;
      if (starve_chk && dma_ack) check("starve_clear", 32'(dut.starve_cnt), 32'd0);
      if (vid_ack) n_vack++;
      if (cpu_ack) n_cack++;
      if (dma_ack) n_dack++;
      if (vid_ack) vid_req = 1'b0;
      if (dma_ack) dma_req = 1'b0;
      if (cpu_ack && (n_cack >= cpu_drop_after)) cpu_req = 1'b0;
    end
  endtask

  // Scoreboard: every ack must match the oldest outstanding expectation.
  exp_t mon_e;
  logic [1:0] mon_who;
  logic [7:0] mon_dout;
  always @(negedge CLK) begin
    if (!reset && (vid_ack || cpu_ack || dma_ack)) begin
      check("ack_onehot", 32'($countones({vid_ack, cpu_ack, dma_ack})), 32'd1);
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'({vid_ack, cpu_ack, dma_ack}), 32'd0);
      end else begin
        mon_e    = sb.pop_front();
        mon_who  = vid_ack ? W_VID : (cpu_ack ? W_CPU : W_DMA);
        mon_dout = vid_ack ? vid_dout : (cpu_ack ? cpu_dout : dma_dout);
        check("ack_owner", 32'(mon_who), 32'(mon_e.who));
        check("ack_dout", 32'(mon_dout), 32'(mon_e.data));
      end
    end
  end

  initial begin
    reset = 1'b1;
    vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = 8'd0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_din = 8'd0;
    mem_data = 8'd0;
    chk_addr = 1'b0; starve_chk = 1'b0; cpu_drop_after = 1;
    exp_addr = '0; exp_din = 8'd0;
    m_vid = 8'd0; m_cpu = 8'd0; m_dma = 8'd0;
    busy_prev = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset state.
    check("rst_mem_oe", 32'(mem_oe), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acks", 32'({vid_ack, cpu_ack, dma_ack}), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_din", 32'(mem_din), 32'd0);
    check("rst_vid_dout", 32'(vid_dout), 32'd0);
    check("rst_cpu_dout", 32'(cpu_dout), 32'd0);
    check("rst_dma_dout", 32'(dma_dout), 32'd0);
    reset = 1'b0;

    // CPU read of 0x00C000 returning 0x5A.
    clear_win();
    mem_data = 8'h5A; cpu_addr = 23'h00C000; cpu_we = 1'b0;
    exp_addr = 23'h00C000; chk_addr = 1'b1;
    m_cpu = 8'h5A; push(W_CPU, m_cpu);
    cpu_req = 1'b1;
    step(8);
    check("rd_oe_cycles", 32'(n_oe), 32'd2);
    check("rd_we_cycles", 32'(n_we), 32'd0);
    check("rd_busy_cycles", 32'(n_busy), 32'd3);
    check("rd_ack_cycles", 32'(n_cack), 32'd1);
    check("rd_addr", 32'(n_addr_bad), 32'd0);
    check("rd_cpu_dout", 32'(cpu_dout), 32'(m_cpu));

    // CPU write 0x12 to 0x004000; cpu_dout must hold.
    clear_win();
    mem_data = 8'hEE; cpu_addr = 23'h004000; cpu_we = 1'b1; cpu_din = 8'h12;
    exp_addr = 23'h004000; exp_din = 8'h12;
    push(W_CPU, m_cpu);
    cpu_req = 1'b1;
    step(8);
    check("wr_we_cycles", 32'(n_we), 32'd2);
    check("wr_oe_cycles", 32'(n_oe), 32'd0);
    check("wr_din", 32'(n_din_bad), 32'd0);
    check("wr_addr", 32'(n_addr_bad), 32'd0);
    check("wr_cpu_dout_hold", 32'(cpu_dout), 32'(m_cpu));

    // Back-to-back CPU reads: grant-to-grant spacing is LAT+2.
    clear_win();
    mem_data = 8'h11; cpu_addr = 23'h00C000; cpu_we = 1'b0;
    exp_addr = 23'h00C000; cpu_drop_after = 2;
    m_cpu = 8'h11; push(W_CPU, m_cpu); push(W_CPU, m_cpu);
    cpu_req = 1'b1;
    step(12);
    cpu_drop_after = 1;
    check("b2b_acks", 32'(n_cack), 32'd2);
    check("b2b_grants", 32'(rises.size()), 32'd2);
    if (rises.size() >= 2) check("b2b_spacing", 32'(rises[1] - rises[0]), 32'd4);

    // Video and CPU request together: video first, CPU in the next IDLE.
    clear_win();
    chk_addr = 1'b0;
    mem_data = 8'hA7; vid_addr = 23'h001000; cpu_addr = 23'h002000;
    m_vid = 8'hA7; m_cpu = 8'hA7;
    push(W_VID, m_vid); push(W_CPU, m_cpu);
    vid_req = 1'b1; cpu_req = 1'b1;
    step(12);
    check("vc_vid_acks", 32'(n_vack), 32'd1);
    check("vc_cpu_acks", 32'(n_cack), 32'd1);
    check("vc_grants", 32'(rises.size()), 32'd2);
    if (rises.size() >= 2) check("vc_spacing", 32'(rises[1] - rises[0]), 32'd4);

    // Video address changed mid-access: mem_addr keeps the granted address.
    clear_win();
    chk_addr = 1'b1; exp_addr = 23'h7FFFFF;
    mem_data = 8'hC3; vid_addr = 23'h7FFFFF;
    m_vid = 8'hC3; push(W_VID, m_vid);
    vid_req = 1'b1;
    step(1);
    vid_addr = 23'h000001;
    step(7);
    check("va_addr_held", 32'(n_addr_bad), 32'd0);
    check("va_oe_cycles", 32'(n_oe), 32'd2);
    check("va_vid_dout", 32'(vid_dout), 32'(m_vid));

    // Busy CPU with pending DMA: order CPU, CPU, CPU, DMA, CPU.
    clear_win();
    chk_addr = 1'b0; starve_chk = 1'b1; cpu_drop_after = 4;
    mem_data = 8'h3C; cpu_we = 1'b0; dma_we = 1'b0;
    cpu_addr = 23'h000200; dma_addr = 23'h000300;
    m_cpu = 8'h3C; m_dma = 8'h3C;
    push(W_CPU, m_cpu); push(W_CPU, m_cpu); push(W_CPU, m_cpu);
    push(W_DMA, m_dma); push(W_CPU, m_cpu);
    cpu_req = 1'b1; dma_req = 1'b1;
    step(26);
    starve_chk = 1'b0; cpu_drop_after = 1;
    check("st_cpu_acks", 32'(n_cack), 32'd4);
    check("st_dma_acks", 32'(n_dack), 32'd1);
    check("st_cnt_final", 32'(dut.starve_cnt), 32'd0);

    // Reset in the second ACCESS cycle of a DMA write, then re-grant.
    clear_win();
    chk_addr = 1'b1; exp_addr = 23'h000100; exp_din = 8'h77;
    dma_we = 1'b1; dma_addr = 23'h000100; dma_din = 8'h77;
    dma_req = 1'b1;
    step(2);
    check("ra_we_before", 32'(mem_we), 32'd1);
    reset = 1'b1;
    step(1);
    check("ra_we_after", 32'(mem_we), 32'd0);
    check("ra_busy_after", 32'(busy), 32'd0);
    check("ra_no_dma_ack", 32'(n_dack), 32'd0);
    check("ra_cpu_dout_clr", 32'(cpu_dout), 32'd0);
    check("ra_vid_dout_clr", 32'(vid_dout), 32'd0);
    m_vid = 8'd0; m_cpu = 8'd0; m_dma = 8'd0;
    push(W_DMA, m_dma);
    reset = 1'b0;
    step(10);
    check("ra_dma_acks", 32'(n_dack), 32'd1);
    check("ra_we_cycles", 32'(n_we), 32'd4);
    check("ra_din", 32'(n_din_bad), 32'd0);
    check("ra_dma_dout", 32'(dma_dout), 32'(m_dma));

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
